// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port cache-line memory arbiter.
// Port indices, line width and the memory's fixed ack latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic PORT_I  = 1'b0;
  localparam logic PORT_D  = 1'b1;
  localparam int   LINE_W  = 256;
  localparam int   MEM_LAT = 8;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way grant picker: combinational winner select plus a round-robin preference pointer.
// Zero-latency grant; the pointer moves only on upd and then prefers the port not just served.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       prio_mode,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       gnt_idx
);

  logic ptr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr <= PORT_I;
    end else if (upd) begin
      ptr <= ~upd_idx;
    end
  end

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt_idx = PORT_I;
    if (req == 2'b10) begin
      gnt_idx = PORT_D;
    end else if (req == 2'b11 && !prio_mode) begin
      gnt_idx = ptr;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory (single outstanding access) between the I-cache and D-cache ports.
// req to pN_ack is 10 cycles at 8-cycle memory latency; a losing requester simply holds req until served.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = LINE_W,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_ack_o,
  input  logic              p1_req_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  state_t            state;
  logic              gnt_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              gnt_idx;

  rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req       ({p1_req_i, p0_req_i}),
    .prio_mode (PRIO_MODE != 0),
    .upd       (state == RESP),
    .upd_idx   (gnt_q),
    .gnt_idx   (gnt_idx)
  );

  // Request inputs are sampled only in IDLE; everything afterwards runs off the latched copy.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      gnt_q   <= PORT_I;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_req_i || p1_req_i) begin
            gnt_q <= gnt_idx;
            if (gnt_idx == PORT_D) begin
              write_q <= p1_write_i;
              addr_q  <= p1_addr_i;
              data_q  <= p1_wdata_i;
            end else begin
              write_q <= p0_write_i;
              addr_q  <= p0_addr_i;
              data_q  <= p0_wdata_i;
            end
            state <= ISSUE;
          end
        end
        ISSUE:   state <= WAIT;
        WAIT:    if (mem_ack_i) state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_enable_o = (state == ISSUE);
  assign mem_write_o  = write_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;

  assign p0_ack_o = (state == RESP) && (gnt_q == PORT_I);
  assign p1_ack_o = (state == RESP) && (gnt_q == PORT_D);
  // Memory read data lands the cycle after its ack, which is exactly RESP.
  assign rdata_o  = (state == RESP) ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and fixed-priority instances, each with a behavioural 8-cycle memory.
// Acks are checked against a scoreboard of expected {instance, port, read line}.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic p0_req [2], p0_write [2], p1_req [2], p1_write [2];
  logic p0_ack [2], p1_ack [2], mem_en [2], mem_wr [2], mem_ack [2], inj_ack [2];
  logic [31:0]       p0_addr [2], p1_addr [2], mem_addr [2];
  logic [LINE_W-1:0] p0_wdata [2], p1_wdata [2], rdata [2], mem_wdata [2], mem_rdata [2];
  int                en_cnt [2] = '{0, 0};

  int errors = 0;
  int checks = 0;

  typedef struct {
    int                inst;
    bit                port;
    bit                wr;
    logic [LINE_W-1:0] rdata;
  } exp_t;
  exp_t sb [$];

  typedef struct {
    bit                port;
    bit                wr;
    logic [31:0]       addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
  } vec_t;

  localparam logic [LINE_W-1:0] L_A5   = {32{8'hA5}};
  localparam logic [LINE_W-1:0] L_1234 = {16{16'h1234}};
  localparam logic [LINE_W-1:0] L_DEAD = {8{32'hDEADBEEF}};
  localparam logic [LINE_W-1:0] L_1    = {32{8'h11}};
  localparam logic [LINE_W-1:0] L_3    = {32{8'h13}};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [LINE_W-1:0] mem [16];
    int                cnt;

    mem_arbiter #(.ADDR_W(32), .DATA_W(LINE_W), .PRIO_MODE(g)) u_dut (
      .clk_i        (clk),
      .rst_i        (rst_n),
      .p0_req_i     (p0_req[g]),
      .p0_write_i   (p0_write[g]),
      .p0_addr_i    (p0_addr[g]),
      .p0_wdata_i   (p0_wdata[g]),
      .p0_ack_o     (p0_ack[g]),
      .p1_req_i     (p1_req[g]),
      .p1_write_i   (p1_write[g]),
      .p1_addr_i    (p1_addr[g]),
      .p1_wdata_i   (p1_wdata[g]),
      .p1_ack_o     (p1_ack[g]),
      .rdata_o      (rdata[g]),
      .mem_enable_o (mem_en[g]),
      .mem_write_o  (mem_wr[g]),
      .mem_addr_o   (mem_addr[g]),
      .mem_data_o   (mem_wdata[g]),
      .mem_ack_i    (mem_ack[g] | inj_ack[g]),
      .mem_data_i   (mem_rdata[g])
    );

    initial begin
      for (int i = 0; i < 16; i++) mem[i] = {32{8'h10 | 8'(i)}};
      mem[2] = L_A5;
    end

    // Memory: ack 8 cycles after the enable cycle, read line valid the cycle after ack.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt          <= 0;
        mem_ack[g]   <= 1'b0;
        mem_rdata[g] <= '0;
      end else begin
        mem_ack[g] <= 1'b0;
        if (cnt > 0) begin
          cnt <= cnt - 1;
          if (cnt == 1) mem_ack[g] <= 1'b1;
        end
        if (mem_ack[g]) begin
          if (mem_wr[g]) mem[mem_addr[g][8:5]] <= mem_wdata[g];
          else           mem_rdata[g] <= mem[mem_addr[g][8:5]];
        end
        if (mem_en[g]) begin
          cnt       <= MEM_LAT - 1;
          en_cnt[g] <= en_cnt[g] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      if (p0_ack[g] || p1_ack[g]) begin
        chk("sb_pending", sb.size() > 0, 1'b1);
        chk("sb_both_acks", p0_ack[g] & p1_ack[g], 1'b0);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_inst", g, e.inst);
          chk("sb_port", p1_ack[g], e.port);
          if (!e.wr) chk("sb_rdata", rdata[g], e.rdata);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic txn(input int g, input bit port, input bit wr, input logic [31:0] addr,
                     input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] rd, input string tag);
    int n;
    int e0;
    sb.push_back('{g, port, wr, rd});
    e0 = en_cnt[g];
    if (port) begin
      p1_write[g] = wr; p1_addr[g] = addr; p1_wdata[g] = wd; p1_req[g] = 1'b1;
    end else begin
      p0_write[g] = wr; p0_addr[g] = addr; p0_wdata[g] = wd; p0_req[g] = 1'b1;
    end
    for (n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (port ? p1_ack[g] : p0_ack[g]) break;
    end
    chk({tag, "_latency"}, n, 10);
    p0_req[g] = 1'b0;
    p1_req[g] = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ack_width"}, port ? p1_ack[g] : p0_ack[g], 1'b0);
    chk({tag, "_enable_pulses"}, en_cnt[g] - e0, 1);
    idle(1);
  endtask

  // Both ports contend; each re-requests the cycle after its ack until its budget runs out.
  task automatic race(input int g, input int k0, input int k1, input logic [3:0] ord, input string tag);
    int left0, left1, got, total;
    bit re0, re1;
    left0 = k0; left1 = k1; total = k0 + k1; got = 0; re0 = 0; re1 = 0;
    for (int i = 0; i < total; i++) sb.push_back('{g, ord[i], 1'b0, ord[i] ? L_3 : L_1});
    p0_write[g] = 1'b0; p0_addr[g] = 32'h20;
    p1_write[g] = 1'b0; p1_addr[g] = 32'h60;
    p0_req[g] = (k0 > 0);
    p1_req[g] = (k1 > 0);
    for (int n = 1; n <= 80 && got < total; n++) begin
      @(posedge clk); #1;
      if (re0) begin p0_req[g] = 1'b1; re0 = 0; end
      if (re1) begin p1_req[g] = 1'b1; re1 = 0; end
      if (p0_ack[g] || p1_ack[g]) begin
        chk({tag, "_order"}, p1_ack[g], ord[got]);
        chk({tag, "_time"}, n, 10 + 11 * got);
        if (p0_ack[g]) begin left0--; p0_req[g] = 1'b0; re0 = (left0 > 0); end
        if (p1_ack[g]) begin left1--; p1_req[g] = 1'b0; re1 = (left1 > 0); end
        got++;
      end
    end
    chk({tag, "_count"}, got, total);
    p0_req[g] = 1'b0;
    p1_req[g] = 1'b0;
    idle(2);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vt [7];
    int   e0;
    bit   seen, stable;
    int   n;

    vt[0] = '{1'b0, 1'b0, 32'h040, '0,     L_A5};
    vt[1] = '{1'b1, 1'b1, 32'h040, L_1234, '0};
    vt[2] = '{1'b0, 1'b0, 32'h040, '0,     L_1234};
    vt[3] = '{1'b1, 1'b0, 32'h080, '0,     {32{8'h14}}};
    vt[4] = '{1'b0, 1'b1, 32'h1E0, L_DEAD, '0};
    vt[5] = '{1'b1, 1'b0, 32'h1E0, '0,     L_DEAD};
    vt[6] = '{1'b0, 1'b0, 32'h000, '0,     {32{8'h10}}};

    for (int g = 0; g < 2; g++) begin
      p0_req[g] = 0; p0_write[g] = 0; p0_addr[g] = '0; p0_wdata[g] = '0;
      p1_req[g] = 0; p1_write[g] = 0; p1_addr[g] = '0; p1_wdata[g] = '0;
      inj_ack[g] = 0;
    end

    #1 rst_n = 1'b0;
    idle(2);
    for (int g = 0; g < 2; g++) begin
      chk("reset_ctl", {p0_ack[g], p1_ack[g], mem_en[g], mem_wr[g]}, 4'b0);
      chk("reset_addr", mem_addr[g], 32'h0);
      chk("reset_data", mem_wdata[g], '0);
    end
    rst_n = 1'b1;
    idle(1);
    for (int g = 0; g < 2; g++) chk("post_reset_ctl", {p0_ack[g], p1_ack[g], mem_en[g]}, 3'b0);

    for (int i = 0; i < 7; i++)
      txn(0, vt[i].port, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].rdata, $sformatf("vec%0d", i));

    // A memory ack while idle must not start or finish anything.
    e0 = en_cnt[0];
    seen = 0;
    inj_ack[0] = 1'b1;
    idle(1);
    inj_ack[0] = 1'b0;
    repeat (4) begin
      seen |= p0_ack[0] | p1_ack[0];
      idle(1);
    end
    chk("stray_ack_resp", seen, 1'b0);
    chk("stray_ack_enable", en_cnt[0] - e0, 0);
    txn(0, 1'b1, 1'b0, 32'h080, '0, {32{8'h14}}, "after_stray");

    // Requester inputs change during WAIT; the memory side must keep the latched copy.
    sb.push_back('{0, 1'b0, 1'b0, L_DEAD});
    p0_write[0] = 1'b0; p0_addr[0] = 32'h1E0; p0_wdata[0] = {8{32'h0BADF00D}}; p0_req[0] = 1'b1;
    stable = 1;
    for (n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (n == 3) begin p0_addr[0] = 32'h040; p0_wdata[0] = {8{32'hCAFEF00D}}; end
      if (p0_ack[0]) break;
      if (n >= 2 && (mem_addr[0] !== 32'h1E0 || mem_wdata[0] !== {8{32'h0BADF00D}})) stable = 0;
    end
    chk("stab_latency", n, 10);
    chk("stab_held", stable, 1'b1);
    chk("stab_addr_resp", mem_addr[0], 32'h1E0);
    p0_req[0] = 1'b0;
    idle(2);

    do_reset();
    race(0, 1, 1, 4'b0010, "rr_first");
    race(0, 2, 2, 4'b1010, "rr_alt");
    race(1, 3, 1, 4'b1000, "prio");

    // Reset lands in WAIT of a port-1 read: no ack, everything drops immediately.
    p1_write[0] = 1'b0; p1_addr[0] = 32'h080; p1_wdata[0] = {8{32'hCAFEF00D}}; p1_req[0] = 1'b1;
    idle(5);
    chk("pre_rst_addr", mem_addr[0], 32'h080);
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", {p0_ack[0], p1_ack[0], mem_en[0], mem_wr[0]}, 4'b0);
    chk("rst_async_addr", mem_addr[0], 32'h0);
    chk("rst_async_data", mem_wdata[0], '0);
    chk("rst_async_rdata", rdata[0], '0);
    p1_req[0] = 1'b0;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      seen |= p0_ack[0] | p1_ack[0];
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      seen |= p0_ack[0] | p1_ack[0];
    end
    chk("rst_no_ack", seen, 1'b0);
    txn(0, 1'b0, 1'b0, 32'h040, '0, L_1234, "post_rst");

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
